// File: rtl/svc_axi_axil_rd.sv
// AXI4 read burst to single-beat AXI-Lite read converter, one burst in flight.
// Define SVC_AXI_AXIL_RD_WRAP_EN to enable WRAP address generation.
module svc_axi_axil_rd #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,

    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,

    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,

    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                m_axil_rresp
);

    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int IDW = AXI_ID_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           arready_q, arready_d;
    logic           arvalid_q, arvalid_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     len_q, len_d;
    logic [2:0]     size_q, size_d;
    logic [1:0]     burst_q, burst_d;
    logic [8:0]     ar_cnt_q, ar_cnt_d;
    logic [8:0]     r_cnt_q, r_cnt_d;

    logic           ar_hs;
    logic           m_ar_hs;
    logic           r_hs;
    logic           last;
    logic [8:0]     ar_cnt_inc;
    logic [AW-1:0]  step;
    logic [AW-1:0]  incr_addr;
    logic [AW-1:0]  next_addr;

    assign ar_hs      = s_axi_arvalid && arready_q && (state_q == IDLE);
    assign m_ar_hs    = arvalid_q && m_axil_arready;
    assign r_hs       = s_axi_rvalid && s_axi_rready;
    assign last       = (state_q == BURST) && (r_cnt_q == {1'b0, len_q});
    assign ar_cnt_inc = ar_cnt_q + 9'd1;
    assign step       = AW'(1) << size_q;
    assign incr_addr  = addr_q + step;

`ifdef SVC_AXI_AXIL_RD_WRAP_EN
    logic [AW-1:0] wrap_mask;

    // Window is (len+1)<<size bytes; only the bits inside it advance.
    assign wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);

    always_comb begin
        next_addr = incr_addr;
        unique case (1'b1)
            (burst_q == 2'b00): next_addr = addr_q;
            (burst_q == 2'b10): next_addr = (addr_q & ~wrap_mask)
                                          | (incr_addr & wrap_mask);
            default:            next_addr = incr_addr;
        endcase
    end
`else
    always_comb begin
        next_addr = incr_addr;
        unique case (1'b1)
            (burst_q == 2'b00): next_addr = addr_q;
            default:            next_addr = incr_addr;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            ar_cnt_q  <= '0;
            r_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            ar_cnt_q  <= ar_cnt_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        ar_cnt_d  = ar_cnt_q;
        r_cnt_d   = r_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d   = BURST;
                    arvalid_d = 1'b1;
                    addr_d    = s_axi_araddr;
                    id_d      = s_axi_arid;
                    len_d     = s_axi_arlen;
                    size_d    = s_axi_arsize;
                    burst_d   = s_axi_arburst;
                    ar_cnt_d  = '0;
                    r_cnt_d   = '0;
                end
            end
            BURST: begin
                if (m_ar_hs) begin
                    ar_cnt_d  = ar_cnt_inc;
                    addr_d    = next_addr;
                    arvalid_d = (ar_cnt_inc <= {1'b0, len_q});
                end
                if (r_hs) begin
                    r_cnt_d = r_cnt_q + 9'd1;
                end
                if (r_hs && last) begin
                    state_d   = IDLE;
                    arvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
    end

    always_comb begin
        s_axi_arready  = arready_q;
        m_axil_arvalid = arvalid_q;
        m_axil_araddr  = addr_q;
        s_axi_rvalid   = m_axil_rvalid && (state_q == BURST);
        m_axil_rready  = s_axi_rready && (state_q == BURST);
        s_axi_rdata    = m_axil_rdata;
        s_axi_rresp    = m_axil_rresp;
        s_axi_rid      = id_q;
        s_axi_rlast    = last;
    end

endmodule

// File: tb/tb_svc_axi_axil_rd.sv
// Directed bench for svc_axi_axil_rd with a small queued AXI-Lite subordinate.
// Expected addresses follow SVC_AXI_AXIL_RD_WRAP_EN for the WRAP step.
module tb_svc_axi_axil_rd;

    logic        clk;
    logic        rst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [19:0] s_axi_araddr;
    logic [3:0]  s_axi_arid;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [3:0]  s_axi_rid;
    logic [15:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [19:0] m_axil_araddr;
    logic        m_axil_rvalid;
    logic        m_axil_rready;
    logic [15:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;

    svc_axi_axil_rd #(
        .AXI_ADDR_WIDTH(20),
        .AXI_DATA_WIDTH(16),
        .AXI_ID_WIDTH  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arid    (s_axi_arid),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_araddr (m_axil_araddr),
        .m_axil_rvalid (m_axil_rvalid),
        .m_axil_rready (m_axil_rready),
        .m_axil_rdata  (m_axil_rdata),
        .m_axil_rresp  (m_axil_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_pass;
    int          cyc;
    int          acc_cyc;
    int          ar_idx;
    int          stall_chk;
    int          stall_bad;
    logic        stall_prev;
    logic [19:0] stall_addr;
    logic        rtoggle;
    logic [15:0] dbase;
    logic [1:0]  sresp;

    logic [19:0] ar_addr_log[$];
    int          ar_cyc_log[$];
    logic [15:0] r_data_log[$];
    logic [3:0]  r_id_log[$];
    logic [1:0]  r_resp_log[$];
    logic        r_last_log[$];
    logic [15:0] pend[$];

    // Handshakes are decided at the negedge; driven values change only at posedge+1.
    always @(negedge clk) begin
        if (m_axil_rvalid && m_axil_rready && pend.size() > 0)
            void'(pend.pop_front());
        if (m_axil_arvalid && m_axil_arready) begin
            ar_addr_log.push_back(m_axil_araddr);
            ar_cyc_log.push_back(cyc + 1);
            pend.push_back(dbase + 16'(ar_idx));
            ar_idx++;
        end
        if (s_axi_rvalid && s_axi_rready) begin
            r_data_log.push_back(s_axi_rdata);
            r_id_log.push_back(s_axi_rid);
            r_resp_log.push_back(s_axi_rresp);
            r_last_log.push_back(s_axi_rlast);
        end
        if (stall_prev) begin
            stall_chk++;
            if (!(m_axil_arvalid && m_axil_araddr == stall_addr))
                stall_bad++;
        end
        stall_prev = m_axil_arvalid && !m_axil_arready;
        stall_addr = m_axil_araddr;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        m_axil_rvalid = (pend.size() > 0);
        m_axil_rdata  = (pend.size() > 0) ? pend[0] : 16'h0;
        m_axil_rresp  = sresp;
        if (rtoggle)
            s_axi_rready = !s_axi_rready;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [19:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt);
        logic got;
        @(posedge clk);
        #1;
        ar_addr_log.delete();
        ar_cyc_log.delete();
        r_data_log.delete();
        r_id_log.delete();
        r_resp_log.delete();
        r_last_log.delete();
        ar_idx        = 0;
        s_axi_araddr  = a;
        s_axi_arid    = id;
        s_axi_arlen   = len;
        s_axi_arsize  = sz;
        s_axi_arburst = bt;
        s_axi_arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (s_axi_arready) begin
                got     = 1'b1;
                acc_cyc = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
        chk("ar_accept", 32'(got), 32'd1);
    endtask

    // Waits for n beats, then checks arready the cycle after the last one.
    task automatic wait_beats(input int n, input string tag);
        int k;
        k = 0;
        while (r_data_log.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(k < 300), 32'd1);
        @(negedge clk);
        chk({tag, "_arready_next"}, 32'(s_axi_arready), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_r_count"}, 32'(r_data_log.size()), 32'(n));
        chk({tag, "_ar_count"}, 32'(ar_addr_log.size()), 32'(n));
    endtask

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        cyc            = 0;
        acc_cyc        = 0;
        ar_idx         = 0;
        stall_chk      = 0;
        stall_bad      = 0;
        stall_prev     = 1'b0;
        stall_addr     = '0;
        rtoggle        = 1'b0;
        dbase          = '0;
        sresp          = 2'd0;
        rst            = 1'b1;
        s_axi_arvalid  = 1'b0;
        s_axi_araddr   = '0;
        s_axi_arid     = '0;
        s_axi_arlen    = '0;
        s_axi_arsize   = '0;
        s_axi_arburst  = '0;
        s_axi_rready   = 1'b1;
        m_axil_arready = 1'b1;
        m_axil_rvalid  = 1'b0;
        m_axil_rdata   = '0;
        m_axil_rresp   = '0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_m_arvalid", 32'(m_axil_arvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_rlast", 32'(s_axi_rlast), 32'd0);
        chk("rst_araddr", 32'(m_axil_araddr), 32'd0);
        chk("rst_rid", 32'(s_axi_rid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_arready", 32'(s_axi_arready), 32'd1);
        chk("post_rst_m_arvalid", 32'(m_axil_arvalid), 32'd0);
        chk("post_rst_rvalid", 32'(s_axi_rvalid), 32'd0);

        // INCR, 4 beats, back-to-back addresses
        dbase = 16'hD000;
        sresp = 2'd0;
        issue(20'hA000, 4'hD, 8'd3, 3'd1, 2'd1);
        wait_beats(4, "incr");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_addr%0d", i), 32'(ar_addr_log[i]),
                32'(20'hA000 + 20'(2 * i)));
            chk($sformatf("incr_cyc%0d", i), 32'(ar_cyc_log[i]),
                32'(acc_cyc + 1 + i));
            chk($sformatf("incr_data%0d", i), 32'(r_data_log[i]),
                32'(16'hD000 + 16'(i)));
            chk($sformatf("incr_rid%0d", i), 32'(r_id_log[i]), 32'hD);
            chk($sformatf("incr_resp%0d", i), 32'(r_resp_log[i]), 32'd0);
            chk($sformatf("incr_last%0d", i), 32'(r_last_log[i]),
                32'(i == 3));
        end

        // FIXED, 3 beats
        dbase = 16'h1230;
        issue(20'h00100, 4'h2, 8'd2, 3'd1, 2'd0);
        wait_beats(3, "fixed");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fixed_addr%0d", i), 32'(ar_addr_log[i]),
                32'h100);
            chk($sformatf("fixed_data%0d", i), 32'(r_data_log[i]),
                32'(16'h1230 + 16'(i)));
            chk($sformatf("fixed_last%0d", i), 32'(r_last_log[i]),
                32'(i == 2));
        end

        // Backpressure: R ready toggles, AXI-Lite AR stalled two cycles
        dbase          = 16'h5000;
        m_axil_arready = 1'b0;
        rtoggle        = 1'b1;
        issue(20'h02000, 4'h3, 8'd3, 3'd1, 2'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        m_axil_arready = 1'b1;
        wait_beats(4, "bp");
        rtoggle = 1'b0;
        @(posedge clk);
        #1;
        s_axi_rready = 1'b1;
        chk("bp_stall_seen", 32'(stall_chk >= 2), 32'd1);
        chk("bp_stall_stable", 32'(stall_bad), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_addr%0d", i), 32'(ar_addr_log[i]),
                32'(20'h2000 + 20'(2 * i)));
            chk($sformatf("bp_data%0d", i), 32'(r_data_log[i]),
                32'(16'h5000 + 16'(i)));
            chk($sformatf("bp_rid%0d", i), 32'(r_id_log[i]), 32'h3);
            chk($sformatf("bp_last%0d", i), 32'(r_last_log[i]),
                32'(i == 3));
        end

        // Single beat carrying SLVERR
        dbase = 16'hEE00;
        sresp = 2'd2;
        issue(20'h00300, 4'h7, 8'd0, 3'd1, 2'd1);
        wait_beats(1, "single");
        chk("single_resp", 32'(r_resp_log[0]), 32'd2);
        chk("single_last", 32'(r_last_log[0]), 32'd1);
        chk("single_data", 32'(r_data_log[0]), 32'hEE00);
        chk("single_rid", 32'(r_id_log[0]), 32'h7);
        sresp = 2'd0;

        // WRAP, 4 beats of 2 bytes starting at 0x6
        dbase = 16'h0A00;
        issue(20'h00006, 4'h1, 8'd3, 3'd1, 2'd2);
        wait_beats(4, "wrap");
`ifdef SVC_AXI_AXIL_RD_WRAP_EN
        chk("wrap_addr0", 32'(ar_addr_log[0]), 32'h6);
        chk("wrap_addr1", 32'(ar_addr_log[1]), 32'h0);
        chk("wrap_addr2", 32'(ar_addr_log[2]), 32'h2);
        chk("wrap_addr3", 32'(ar_addr_log[3]), 32'h4);
`else
        chk("wrap_addr0", 32'(ar_addr_log[0]), 32'h6);
        chk("wrap_addr1", 32'(ar_addr_log[1]), 32'h8);
        chk("wrap_addr2", 32'(ar_addr_log[2]), 32'hA);
        chk("wrap_addr3", 32'(ar_addr_log[3]), 32'hC);
`endif
        chk("wrap_last3", 32'(r_last_log[3]), 32'd1);
        chk("wrap_idle_arvalid", 32'(m_axil_arvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/svc_axi_axil_rd.md
# svc_axi_axil_rd

Converts AXI4 read bursts into a sequence of single-beat AXI-Lite reads and returns the AXI-Lite read data as AXI4 R beats carrying the burst's ID and RLAST. It is the read-side companion of the AXI-to-AXI-Lite write converter. It sits between an AXI4 manager (or interconnect port) and an AXI-Lite register or memory subordinate. One burst is in flight at a time. Within a burst, AXI-Lite addresses are issued back-to-back while read data streams through.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 20, address width (AW)
- AXI_DATA_WIDTH, 16, data width (DW); byte lanes = DW/8
- AXI_ID_WIDTH, 4, ID width (IDW)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axi_arvalid / s_axi_arready  in / out  1  burst address handshake
- s_axi_araddr  in  AW  burst start address
- s_axi_arid  in  IDW  burst ID
- s_axi_arlen  in  8  beats minus one
- s_axi_arsize  in  3  log2 bytes per beat; must be ≤ log2(DW/8)
- s_axi_arburst  in  2  0 FIXED, 1 INCR, 2 WRAP
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake
- s_axi_rid  out  IDW  captured arid
- s_axi_rdata  out  DW  read data
- s_axi_rresp  out  2  per-beat response
- s_axi_rlast  out  1  final beat of burst
- m_axil_arvalid / m_axil_arready  out / in  1  AXI-Lite address handshake
- m_axil_araddr  out  AW  per-beat address
- m_axil_rvalid / m_axil_rready  in / out  1  AXI-Lite data handshake
- m_axil_rdata  in  DW  read data
- m_axil_rresp  in  2  response

## Operation
- States:
  - IDLE: s_axi_arready=1.
  - BURST: s_axi_arready=0.
- IDLE→BURST on the arvalid&&arready handshake. The block captures addr, id, len, size, and burst.
- Counters:
  - ar_cnt counts issued AXI-Lite addresses.
  - r_cnt counts returned AXI4 beats.
  - Both are 9 bits and cleared on accept.
- Address issue:
  - m_axil_arvalid is registered and high while ar_cnt ≤ len.
  - On each m_axil handshake, ar_cnt increments and the next address loads.
  - INCR: addr += 1<<size.
  - FIXED: addr unchanged.
  - WRAP: see Configuration.
  - Address arithmetic is modulo 2^AW.
- Data return is combinational pass-through:
  - s_axi_rvalid = m_axil_rvalid && state==BURST.
  - m_axil_rready = s_axi_rready && state==BURST.
  - rdata and rresp are passed through unchanged.
  - s_axi_rid = captured id.
  - s_axi_rlast = (r_cnt == len).
- r_cnt increments on each s_axi R handshake. The handshake with rlast=1 returns the block to IDLE.
- The address side may run ahead of the data side. The AXI-Lite subordinate holds its responses.
- An error rresp on any beat does not abort the burst. All len+1 beats are issued and returned.
- arlen=0 gives a single beat with rlast=1 on that beat.
- Any AXI-Lite rvalid in IDLE is ignored (rready=0); it cannot occur with a compliant subordinate.

## Timing
- Reset values:
  - s_axi_arready=0, then 1 the first cycle after reset deasserts.
  - m_axil_arvalid=0, s_axi_rvalid=0, s_axi_rlast=0, state=IDLE.
  - m_axil_araddr=0 and s_axi_rid=0.
- Burst accepted in cycle N: m_axil_arvalid is high in cycle N+1 with araddr = start address.
- With m_axil_arready held high, one address issues per cycle: beats at N+1..N+1+len.
- R latency is zero cycles: s_axi_rvalid follows m_axil_rvalid in the same cycle.
- After the final R handshake in cycle M:
  - s_axi_arready=1 in cycle M+1.
  - The minimum gap between bursts is one cycle.
- m_axil_arvalid, once high, stays high with a stable address until the handshake.
- A reset asserted mid-burst abandons the burst immediately; all outputs take their reset values next cycle. No partial beats are completed.

## Configuration
- SVC_AXI_AXIL_RD_WRAP_EN defined:
  - WRAP bursts wrap within the aligned window of (len+1)<<size bytes. The bits of the address below the window boundary increment; the upper bits are held.
  - len must be 1, 3, 7, or 15. Other values are undefined.
- Not defined: WRAP is treated exactly as INCR, with no wrap logic synthesized.

## Test plan
- Reset: after rst, the bench checks s_axi_arready=1, m_axil_arvalid=0, s_axi_rvalid=0.
- INCR, 4 beats:
  - Stimulus: araddr=0xA000, arid=0xD, arlen=3, arsize=1; subordinate ready every cycle, returning rdata 0xD000+i.
  - Required: araddr 0xA000/0xA002/0xA004/0xA006 on consecutive cycles; rid=0xD and rresp=0 on every beat; rlast only on beat 3.
- FIXED, 3 beats:
  - Stimulus: araddr=0x0100, arlen=2.
  - Required: all three AXI-Lite addresses are 0x0100; rlast on beat 2.
- Backpressure:
  - Stimulus: s_axi_rready toggles 1/0 and m_axil_arready is low for 2 cycles, on a 4-beat INCR burst.
  - Required: addresses are stable while stalled, data beats are not dropped or duplicated, and the burst completes with exactly 4 R handshakes.
- Error and single beat:
  - Stimulus: arlen=0 with subordinate rresp=2.
  - Required: one beat with rresp=2 and rlast=1; arready=1 the next cycle.
- WRAP (macro defined):
  - Stimulus: araddr=0x0006, arlen=3, arsize=1.
  - Required: addresses 0x0006, 0x0000, 0x0002, 0x0004.
- WRAP (macro not defined), same stimulus:
  - Required: addresses 0x0006, 0x0008, 0x000A, 0x000C.
